merge_phase: RTL and testbench

MERGE_PHASE -- requirements
Module: merge_phase

---
 rtl/merge_phase.sv | 179 +++++++++++++++++
 tb/tb_merge_phase.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_phase.sv
// One bottom-up merge-sort pass: pairs of sorted runs of length L are streamed
// from the source bank, merged stably, and written to the destination bank.
module merge_phase #(
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en_in,
  input  logic                       start_in,
  input  logic [31:0]                stream_len_in,
  input  logic [31:0]                run_len_in,
  output logic [BANK_ADDR_WIDTH-1:0] src_a_addr_out,
  output logic [BANK_ADDR_WIDTH-1:0] src_b_addr_out,
  output logic                       src_a_read_en,
  output logic                       src_b_read_en,
  input  logic [DATA_WIDTH-1:0]      src_a_data_in,
  input  logic [DATA_WIDTH-1:0]      src_b_data_in,
  output logic [BANK_ADDR_WIDTH-1:0] dst_addr_out,
  output logic [DATA_WIDTH-1:0]      dst_data_out,
  output logic                       dst_write_en,
  output logic                       pass_done_out
);
  typedef logic [DATA_WIDTH-1:0] tuple_pair_t;
  typedef enum logic [2:0] {IDLE, PRIME, MERGE, DRAIN, DONE} state_t;

  state_t      r_state, w_nextState;
  logic [31:0] r_n, r_l, r_base, r_pairEnd, r_wrAddr;
  logic [31:0] r_rdAddr [2];
  logic [31:0] r_rdEnd  [2];
  tuple_pair_t r_buf    [2][2];
  logic [1:0]  r_cnt    [2];
  logic [1:0]  r_pend;
  logic        r_passDone;

  tuple_pair_t w_rdData [2];
  tuple_pair_t w_nxtBuf [2][2];
  logic [1:0]  w_nxtCnt [2];
  logic [1:0]  w_tot    [2];
  logic [1:0]  w_has, w_empty, w_headOk, w_pop, w_rd;
  logic        w_go, w_active, w_emit, w_start, w_lastWr, w_passEnd, w_setup;
  logic [31:0] w_n, w_l, w_setN, w_setL, w_setBase, w_aEnd, w_bEnd;

  assign w_go        = en_in && !reset;
  assign w_active    = (r_state == PRIME) || (r_state == MERGE) || (r_state == DRAIN);
  assign w_emit      = w_go && ((r_state == MERGE) || (r_state == DRAIN));
  assign w_start     = w_go && start_in && ((r_state == IDLE) || (r_state == DONE));
  assign w_rdData[0] = src_a_data_in;
  assign w_rdData[1] = src_b_data_in;

  // A run length covering the whole padded stream degenerates into a plain copy.
  assign w_n       = ((stream_len_in >> 4) + 32'd1) << 4;
  assign w_l       = (run_len_in >= w_n) ? w_n : run_len_in;
  assign w_setN    = w_start ? w_n : r_n;
  assign w_setL    = w_start ? w_l : r_l;
  assign w_setBase = w_start ? 32'd0 : r_base + (r_l << 1);
  assign w_aEnd    = (w_setBase + w_setL >= w_setN) ? w_setN : w_setBase + w_setL;
  assign w_bEnd    = (w_setBase + (w_setL << 1) >= w_setN) ? w_setN : w_setBase + (w_setL << 1);

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_has[s]    = (r_cnt[s] != 2'd0);
      w_empty[s]  = (r_rdAddr[s] >= r_rdEnd[s]) && !w_has[s] && !r_pend[s];
      w_headOk[s] = w_has[s] || w_empty[s];
      w_tot[s]    = r_cnt[s] + {1'b0, r_pend[s]};
    end
  end

  // Ties go to A so equal keys keep their original order.
  always_comb begin
    w_pop = 2'b00;
    if (w_emit) begin
      if (w_has[0] && w_has[1]) begin
        if (r_buf[0][0] <= r_buf[1][0]) w_pop = 2'b01;
        else                            w_pop = 2'b10;
      end else if (w_has[0] && w_empty[1]) begin
        w_pop = 2'b01;
      end else if (w_has[1] && w_empty[0]) begin
        w_pop = 2'b10;
      end
    end
  end

  assign dst_write_en = |w_pop;
  assign dst_data_out = w_pop[0] ? r_buf[0][0] : (w_pop[1] ? r_buf[1][0] : '0);
  assign w_lastWr     = dst_write_en && (r_wrAddr == r_pairEnd - 32'd1);
  assign w_passEnd    = (r_pairEnd >= r_n);
  assign w_setup      = w_start || (w_lastWr && !w_passEnd);

  // Issue a read whenever buffered plus in-flight data would leave a free slot;
  // returning data is always captured, even while stalled.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_rd[s]     = w_go && w_active && (r_rdAddr[s] < r_rdEnd[s]) &&
                    ((w_tot[s] < 2'd2) || w_pop[s]);
      w_nxtBuf[s] = r_buf[s];
      w_nxtCnt[s] = r_cnt[s];
      if (w_pop[s]) begin
        w_nxtBuf[s][0] = r_buf[s][1];
        w_nxtCnt[s]    = r_cnt[s] - 2'd1;
      end
      if (r_pend[s]) begin
        if (w_nxtCnt[s] == 2'd0) w_nxtBuf[s][0] = w_rdData[s];
        else                     w_nxtBuf[s][1] = w_rdData[s];
        w_nxtCnt[s] = w_nxtCnt[s] + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_go) begin
      case (r_state)
        IDLE, DONE: if (start_in) w_nextState = PRIME;
        PRIME:      if (w_headOk == 2'b11) w_nextState = (|w_empty) ? DRAIN : MERGE;
        MERGE, DRAIN: begin
          if (w_lastWr)      w_nextState = w_passEnd ? DONE : PRIME;
          else if (|w_empty) w_nextState = DRAIN;
        end
        default:    w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_n        <= '0;
      r_l        <= '0;
      r_base     <= '0;
      r_pairEnd  <= '0;
      r_wrAddr   <= '0;
      r_pend     <= '0;
      r_passDone <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        r_rdAddr[s] <= '0;
        r_rdEnd[s]  <= '0;
        r_cnt[s]    <= '0;
        r_buf[s][0] <= '0;
        r_buf[s][1] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        r_buf[s] <= w_nxtBuf[s];
        r_cnt[s] <= w_nxtCnt[s];
        if (w_rd[s]) r_rdAddr[s] <= r_rdAddr[s] + 32'd1;
      end
      r_pend <= w_rd;
      if (w_start) begin
        r_n <= w_n;
        r_l <= w_l;
      end
      if (w_setup) begin
        r_base      <= w_setBase;
        r_rdAddr[0] <= w_setBase;
        r_rdEnd[0]  <= w_aEnd;
        r_rdAddr[1] <= w_aEnd;
        r_rdEnd[1]  <= w_bEnd;
        r_pairEnd   <= w_bEnd;
        r_wrAddr    <= w_setBase;
      end else if (dst_write_en) begin
        r_wrAddr <= r_wrAddr + 32'd1;
      end
      if (w_start)                     r_passDone <= 1'b0;
      else if (w_lastWr && w_passEnd)  r_passDone <= 1'b1;
    end
  end

  assign src_a_addr_out = r_rdAddr[0][BANK_ADDR_WIDTH-1:0];
  assign src_b_addr_out = r_rdAddr[1][BANK_ADDR_WIDTH-1:0];
  assign src_a_read_en  = w_rd[0];
  assign src_b_read_en  = w_rd[1];
  assign dst_addr_out   = r_wrAddr[BANK_ADDR_WIDTH-1:0];
  assign pass_done_out  = r_passDone;
endmodule

// File: tb/tb_merge_phase.sv
// Scoreboard bench for merge_phase: expected writes are modelled from the
// source bank contents when a pass is started and compared against the writes seen.
`timescale 1ns/1ps
module tb_merge_phase;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } obs_t;

  logic          clock = 1'b0;
  logic          reset, en_in, start_in;
  logic [31:0]   stream_len_in, run_len_in;
  logic [AW-1:0] src_a_addr_out, src_b_addr_out, dst_addr_out;
  logic          src_a_read_en, src_b_read_en, dst_write_en, pass_done_out;
  logic [DW-1:0] src_a_data_in, src_b_data_in, dst_data_out;

  logic [DW-1:0] mem [0:255];
  wr_t  expQ [$];
  obs_t obsQ [$];
  int   cyc = 0;
  int   stallWrites = 0;
  int   checkCount = 0;
  int   passCount = 0;

  merge_phase #(.BANK_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .en_in(en_in), .start_in(start_in),
    .stream_len_in(stream_len_in), .run_len_in(run_len_in),
    .src_a_addr_out(src_a_addr_out), .src_b_addr_out(src_b_addr_out),
    .src_a_read_en(src_a_read_en), .src_b_read_en(src_b_read_en),
    .src_a_data_in(src_a_data_in), .src_b_data_in(src_b_data_in),
    .dst_addr_out(dst_addr_out), .dst_data_out(dst_data_out),
    .dst_write_en(dst_write_en), .pass_done_out(pass_done_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Source bank: both ports read the same storage with one cycle of latency.
  always @(posedge clock) begin
    if (src_a_read_en) src_a_data_in <= mem[src_a_addr_out[7:0]];
    if (src_b_read_en) src_b_data_in <= mem[src_b_addr_out[7:0]];
  end

  always @(negedge clock) begin
    if (dst_write_en) begin
      obsQ.push_back('{cyc, dst_addr_out, dst_data_out});
      if (!en_in) stallWrites <= stallWrites + 1;
    end
  end

  task automatic fillRuns(input int n, input int l, input int streamLen);
    logic [DW-1:0] v;
    for (int r = 0; r < n; r += l) begin
      v = DW'($urandom_range(0, 20));
      for (int i = r; i < ((r + l < n) ? r + l : n); i++) begin
        mem[i] = v;
        v = v + DW'($urandom_range(0, 3));
      end
    end
    for (int i = streamLen + 1; i < n; i++) mem[i] = '1;
  endtask

  // Reference merge of the current bank contents into the expected write queue.
  task automatic buildExpected(input int streamLen, input int runLen);
    int n, l, ia, ea, ib, eb, k;
    expQ.delete();
    n = ((streamLen >> 4) + 1) << 4;
    l = (runLen >= n) ? n : runLen;
    k = 0;
    for (int base = 0; base < n; base += 2 * l) begin
      ia = base;
      ea = (base + l < n) ? base + l : n;
      ib = ea;
      eb = (base + 2 * l < n) ? base + 2 * l : n;
      while (ia < ea || ib < eb) begin
        if (ib >= eb || (ia < ea && mem[ia] <= mem[ib])) begin
          expQ.push_back('{AW'(k), mem[ia]});
          ia++;
        end else begin
          expQ.push_back('{AW'(k), mem[ib]});
          ib++;
        end
        k++;
      end
    end
  endtask

  task automatic startPass(input int streamLen, input int runLen);
    @(posedge clock); #1;
    stream_len_in = 32'(streamLen);
    run_len_in    = 32'(runLen);
    start_in      = 1'b1;
    @(posedge clock); #1;
    start_in      = 1'b0;
    stream_len_in = 32'd5;
    run_len_in    = 32'd16;
  endtask

  task automatic waitDone(input int maxCyc, output int doneCyc);
    doneCyc = -1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clock);
      if (pass_done_out) begin
        doneCyc = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; en_in = 1'b1; start_in = 1'b0;
    stream_len_in = '0; run_len_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkCount++;
    if ({src_a_addr_out, src_b_addr_out, dst_addr_out} !== '0)
      $display("[TB] FAIL reset_addr: got a=%0d b=%0d dst=%0d, required all 0", src_a_addr_out, src_b_addr_out, dst_addr_out);
    else passCount++;
    checkCount++;
    if ({src_a_read_en, src_b_read_en, dst_write_en} !== 3'b000)
      $display("[TB] FAIL reset_strobes: got %b, required 000", {src_a_read_en, src_b_read_en, dst_write_en});
    else passCount++;
    checkCount++;
    if ({dst_data_out, pass_done_out} !== '0)
      $display("[TB] FAIL reset_data_done: got data=%0h done=%b, required 0/0", dst_data_out, pass_done_out);
    else passCount++;
  endtask

  task automatic test_interleave;
    int base, idx, doneCyc;
    wr_t e;
    for (int i = 0; i < 16; i++) begin
      mem[i]      = DW'(2 * i);
      mem[16 + i] = DW'(2 * i + 1);
    end
    buildExpected(31, 16);
    base = obsQ.size();
    startPass(31, 16);
    repeat (10) @(posedge clock);
    #1 start_in = 1'b1; stream_len_in = 32'd15;
    @(posedge clock); #1 start_in = 1'b0;
    waitDone(300, doneCyc);
    checkCount++;
    if (doneCyc < 0) $display("[TB] FAIL interleave_done: pass_done low, required high within 300 cycles");
    else passCount++;
    idx = base;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (idx >= obsQ.size())
        $display("[TB] FAIL interleave_write: addr %0d not written, required data %0h", e.addr, e.data);
      else if (obsQ[idx].addr !== e.addr || obsQ[idx].data !== e.data || obsQ[idx].data !== DW'(obsQ[idx].addr))
        $display("[TB] FAIL interleave_write: got addr %0d data %0h, required addr %0d data %0h",
                 obsQ[idx].addr, obsQ[idx].data, e.addr, e.data);
      else passCount++;
      idx++;
    end
    checkCount++;
    if (obsQ.size() !== idx) $display("[TB] FAIL interleave_count: got %0d writes, required 32", obsQ.size() - base);
    else passCount++;
    if (obsQ.size() >= base + 32) begin
      checkCount++;
      if (obsQ[base + 31].cyc - obsQ[base].cyc !== 31)
        $display("[TB] FAIL interleave_rate: got span %0d cycles, required 31", obsQ[base + 31].cyc - obsQ[base].cyc);
      else passCount++;
      checkCount++;
      if (doneCyc !== obsQ[base + 31].cyc + 1)
        $display("[TB] FAIL interleave_done_time: got cycle %0d, required %0d", doneCyc, obsQ[base + 31].cyc + 1);
      else passCount++;
    end
  endtask

  task automatic test_no_b;
    int base, idx, doneCyc;
    wr_t e;
    fillRuns(48, 16, 47);
    buildExpected(47, 16);
    base = obsQ.size();
    startPass(47, 16);
    waitDone(400, doneCyc);
    checkCount++;
    if (doneCyc < 0) $display("[TB] FAIL nob_done: pass_done low, required high within 400 cycles");
    else passCount++;
    idx = base;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (idx >= obsQ.size())
        $display("[TB] FAIL nob_write: addr %0d not written, required data %0h", e.addr, e.data);
      else if (obsQ[idx].addr !== e.addr || obsQ[idx].data !== e.data)
        $display("[TB] FAIL nob_write: got addr %0d data %0h, required addr %0d data %0h",
                 obsQ[idx].addr, obsQ[idx].data, e.addr, e.data);
      else passCount++;
      idx++;
    end
    checkCount++;
    if (obsQ.size() !== idx) $display("[TB] FAIL nob_count: got %0d writes, required 48", obsQ.size() - base);
    else passCount++;
    if (obsQ.size() >= base + 48) begin
      checkCount++;
      if (doneCyc !== obsQ[base + 47].cyc + 1)
        $display("[TB] FAIL nob_done_time: got cycle %0d, required %0d", doneCyc, obsQ[base + 47].cyc + 1);
      else passCount++;
    end
  endtask

  task automatic test_duplicates;
    int base, idx, doneCyc;
    wr_t e;
    logic [DW-1:0] head [5];
    head = '{DW'(5), DW'(5), DW'(5), DW'(7), DW'(9)};
    mem[0] = 5; mem[1] = 5; mem[16] = 5; mem[17] = 7;
    for (int i = 2; i < 16; i++) begin
      mem[i]      = DW'(7 + i);
      mem[16 + i] = DW'(6 + 2 * i);
    end
    buildExpected(31, 16);
    base = obsQ.size();
    startPass(31, 16);
    waitDone(300, doneCyc);
    checkCount++;
    if (doneCyc < 0) $display("[TB] FAIL dup_done: pass_done low, required high within 300 cycles");
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if (obsQ.size() <= base + i || obsQ[base + i].data !== head[i])
        $display("[TB] FAIL dup_head: write %0d wrong or missing, required data %0d", i, head[i]);
      else passCount++;
    end
    idx = base;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (idx >= obsQ.size())
        $display("[TB] FAIL dup_write: addr %0d not written, required data %0h", e.addr, e.data);
      else if (obsQ[idx].addr !== e.addr || obsQ[idx].data !== e.data)
        $display("[TB] FAIL dup_write: got addr %0d data %0h, required addr %0d data %0h",
                 obsQ[idx].addr, obsQ[idx].data, e.addr, e.data);
      else passCount++;
      idx++;
    end
  endtask

  task automatic test_stall;
    int base, idx, stallBase;
    wr_t e;
    fillRuns(32, 16, 28);
    buildExpected(28, 16);
    base = obsQ.size();
    stallBase = stallWrites;
    startPass(28, 16);
    for (int i = 0; i < 600 && !pass_done_out; i++) begin
      @(posedge clock); #1;
      en_in = 1'($urandom_range(0, 1));
    end
    en_in = 1'b1;
    @(negedge clock);
    checkCount++;
    if (!pass_done_out) $display("[TB] FAIL stall_done: pass_done low, required high within 600 cycles");
    else passCount++;
    checkCount++;
    if (stallWrites !== stallBase)
      $display("[TB] FAIL stall_write_gate: got %0d writes while en_in=0, required 0", stallWrites - stallBase);
    else passCount++;
    idx = base;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (idx >= obsQ.size())
        $display("[TB] FAIL stall_write: addr %0d not written, required data %0h", e.addr, e.data);
      else if (obsQ[idx].addr !== e.addr || obsQ[idx].data !== e.data)
        $display("[TB] FAIL stall_write: got addr %0d data %0h, required addr %0d data %0h",
                 obsQ[idx].addr, obsQ[idx].data, e.addr, e.data);
      else passCount++;
      idx++;
    end
    checkCount++;
    if (obsQ.size() !== idx) $display("[TB] FAIL stall_count: got %0d writes, required 32", obsQ.size() - base);
    else passCount++;
  endtask

  task automatic test_reset_mid;
    int base, idx, doneCyc;
    wr_t e;
    fillRuns(32, 16, 31);
    buildExpected(31, 16);
    base = obsQ.size();
    startPass(31, 16);
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (obsQ.size() - base >= 9) break;
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkCount++;
    if ({src_a_addr_out, src_b_addr_out, dst_addr_out, src_a_read_en, src_b_read_en,
         dst_write_en, dst_data_out, pass_done_out} !== '0)
      $display("[TB] FAIL midreset_outputs: got a=%0d b=%0d dst=%0d en=%b%b%b data=%0h done=%b, required all 0",
               src_a_addr_out, src_b_addr_out, dst_addr_out, src_a_read_en, src_b_read_en,
               dst_write_en, dst_data_out, pass_done_out);
    else passCount++;
    repeat (5) @(negedge clock);
    checkCount++;
    if (obsQ.size() - base !== 9)
      $display("[TB] FAIL midreset_abort: got %0d writes, required 9", obsQ.size() - base);
    else passCount++;
    fillRuns(32, 16, 31);
    buildExpected(31, 16);
    base = obsQ.size();
    startPass(31, 16);
    waitDone(300, doneCyc);
    checkCount++;
    if (doneCyc < 0) $display("[TB] FAIL midreset_done: pass_done low, required high within 300 cycles");
    else passCount++;
    idx = base;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (idx >= obsQ.size())
        $display("[TB] FAIL midreset_write: addr %0d not written, required data %0h", e.addr, e.data);
      else if (obsQ[idx].addr !== e.addr || obsQ[idx].data !== e.data)
        $display("[TB] FAIL midreset_write: got addr %0d data %0h, required addr %0d data %0h",
                 obsQ[idx].addr, obsQ[idx].data, e.addr, e.data);
      else passCount++;
      idx++;
    end
  endtask

  task automatic test_copy_through;
    int base, idx, doneCyc;
    wr_t e;
    fillRuns(32, 64, 25);
    buildExpected(25, 64);
    base = obsQ.size();
    startPass(25, 64);
    waitDone(300, doneCyc);
    checkCount++;
    if (doneCyc < 0) $display("[TB] FAIL copy_done: pass_done low, required high within 300 cycles");
    else passCount++;
    idx = base;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (idx >= obsQ.size())
        $display("[TB] FAIL copy_write: addr %0d not written, required data %0h", e.addr, e.data);
      else if (obsQ[idx].addr !== e.addr || obsQ[idx].data !== e.data)
        $display("[TB] FAIL copy_write: got addr %0d data %0h, required addr %0d data %0h",
                 obsQ[idx].addr, obsQ[idx].data, e.addr, e.data);
      else passCount++;
      idx++;
    end
    checkCount++;
    if (obsQ.size() !== base + 32 || obsQ[base + 31].data !== '1)
      $display("[TB] FAIL copy_tail: got %0d writes, required 32 ending in all-ones padding", obsQ.size() - base);
    else passCount++;
  endtask

  initial begin
    test_reset;
    test_interleave;
    test_no_b;
    test_duplicates;
    test_stall;
    test_reset_mid;
    test_copy_through;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
